// File: rtl/seg7_scan_mux_pkg.sv
// Shared definitions for the 7-segment scan driver: digit limits, BCD type and
// output polarity helper.
package seg7_scan_mux_pkg;

    localparam int MAX_DIGITS = 8;

    typedef logic [3:0] bcd_t;

    // Map a logical "on" request to the pin level for the given polarity.
    function automatic logic drive_level(input logic on, input logic active_low);
        return on ^ active_low;
    endfunction

endpackage

// File: rtl/seg7_scan_mux_tick_divider.sv
// Mod-DIV counter with a terminal-count flag; the running count is exposed so
// the scan logic can time the anti-ghost gap at the start of each slot.
module seg7_scan_mux_tick_divider #(
    parameter int DIV = 50000,
    parameter int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic [CW-1:0] count,
    output logic          tc
);

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    assign tc = (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || tc)
            count <= '0;
        else
            count <= count + CW'(1);
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed scan driver for an N-digit 7-segment display with tear-free
// frame updates, anti-ghost blanking gap and optional leading-zero blanking.
module seg7_scan_mux
    import seg7_scan_mux_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter int BLANK_GAP     = 500,
    parameter int AN_ACTIVE_LOW = 1,
    parameter int DP_ACTIVE_LOW = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          load,
    input  logic                          blank_lz,
    output bcd_t                          bcd_out,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          dp_out,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_tick
);

    localparam int            IW       = $clog2(NUM_DIGITS);
    localparam int            CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] GAP_C    = CW'(BLANK_GAP);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic          AN_LOW   = (AN_ACTIVE_LOW != 0);
    localparam logic          DP_LOW   = (DP_ACTIVE_LOW != 0);

    logic [CW-1:0]           cnt;
    logic                    slot_end;
    logic                    frame_wrap;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow_dig;
    logic [4*NUM_DIGITS-1:0] active_dig;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   active_dp;
    logic                    lz;
    logic [NUM_DIGITS-1:0]   blanked;
    logic                    zero_above;
    logic                    in_gap;
    bcd_t                    cur_digit;
    logic                    cur_blank;
    logic                    cur_dp;
    logic [NUM_DIGITS-1:0]   an_next;

    seg7_scan_mux_tick_divider #(
        .DIV (REFRESH_DIV),
        .CW  (CW)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .count (cnt),
        .tc    (slot_end)
    );

    assign frame_wrap = slot_end && (idx == LAST_IDX);

    // Digits only move from shadow to active on the wrap into slot 0, so a
    // frame never mixes old and new values; a load on that same edge lands in
    // shadow and waits one more frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            shadow_dig <= '0;
            shadow_dp  <= '0;
            active_dig <= '0;
            active_dp  <= '0;
            lz         <= 1'b0;
        end else begin
            if (load) begin
                shadow_dig <= digits_in;
                shadow_dp  <= dp_in;
            end
            if (slot_end)
                idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
            if (frame_wrap) begin
                active_dig <= shadow_dig;
                active_dp  <= shadow_dp;
                lz         <= blank_lz;
            end
        end
    end

    // Walk down from the top digit; a digit is blanked while every digit at
    // or above it is zero. Digit 0 is never blanked.
    always_comb begin
        blanked    = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above && (active_dig[4*k +: 4] == 4'h0);
            blanked[k] = lz && zero_above;
        end
    end

    assign in_gap    = (cnt < GAP_C);
    assign cur_digit = active_dig[{idx, 2'b00} +: 4];
    assign cur_blank = blanked[idx];
    assign cur_dp    = active_dp[idx];

    always_comb begin
        an_next = '0;
        for (int k = 0; k < NUM_DIGITS; k++)
            an_next[k] = drive_level(!in_gap && !cur_blank && (IW'(k) == idx), AN_LOW);
    end

    // Output register stage: everything the display sees lags scan state by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_out    <= '0;
            an         <= {NUM_DIGITS{AN_LOW}};
            dp_out     <= DP_LOW;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
        end else begin
            bcd_out    <= cur_digit;
            an         <= an_next;
            dp_out     <= drive_level(cur_dp && !cur_blank, DP_LOW);
            digit_idx  <= idx;
            frame_tick <= (cnt == '0) && (idx == '0);
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux: directed scenarios plus randomized
// loads, all compared cycle by cycle against a frame-level reference model.
module tb_seg7_scan_mux;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int GAP   = 1;
    localparam int FRAME = N * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  bcd_out;
    logic [3:0]  an;
    logic        dp_out;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: k = clock edges since reset release.
    int          k = 0;
    logic [15:0] m_shadow = '0, m_active = '0;
    logic [3:0]  m_shadow_dp = '0, m_active_dp = '0;
    logic        m_lz = 1'b0;
    logic [11:0] exp_vec;
    logic [11:0] act_vec;

    assign act_vec = {bcd_out, an, dp_out, digit_idx, frame_tick};

    seg7_scan_mux #(
        .NUM_DIGITS    (N),
        .REFRESH_DIV   (DIV),
        .BLANK_GAP     (GAP),
        .AN_ACTIVE_LOW (1),
        .DP_ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .bcd_out    (bcd_out),
        .an         (an),
        .dp_out     (dp_out),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Advance one clock and derive the expected outputs from the display rules:
    // output at time t shows slot (t/DIV)%N, position t%DIV, of the frame
    // snapshot taken at the last frame boundary.
    task automatic step();
        logic        s_rst, s_load, s_blz;
        logic [15:0] s_dig;
        logic [3:0]  s_dp;
        int          t, s, p;
        logic [3:0]  d, e_an;
        logic        blk, e_dp;
        @(posedge clk);
        s_rst  = rst;
        s_load = load;
        s_blz  = blank_lz;
        s_dig  = digits_in;
        s_dp   = dp_in;
        #1;
        load = 1'b0;
        if (s_rst) begin
            k = 0;
            m_shadow = '0; m_shadow_dp = '0;
            m_active = '0; m_active_dp = '0;
            m_lz = 1'b0;
            exp_vec = {4'h0, 4'hF, 1'b1, 2'd0, 1'b0};
        end else begin
            k++;
            t    = k - 1;
            s    = (t / DIV) % N;
            p    = t % DIV;
            d    = 4'(m_active >> (4 * s));
            blk  = m_lz && (s != 0) && ((m_active >> (4 * s)) == 16'h0);
            e_an = (p < GAP || blk) ? 4'hF : ~(4'(1) << s);
            e_dp = !(m_active_dp[s] && !blk);
            exp_vec = {d, e_an, e_dp, 2'(s), (t % FRAME == 0)};
            if (k % FRAME == 0) begin
                m_active    = m_shadow;
                m_active_dp = m_shadow_dp;
                m_lz        = s_blz;
            end
            if (s_load) begin
                m_shadow    = s_dig;
                m_shadow_dp = s_dp;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL reset: got %h expected %h", act_vec, exp_vec);
            end
        end
        rst = 1'b0;
        repeat (8) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL reset_release k=%0d: got %h expected %h", k, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_basic_scan();
        blank_lz  = 1'b0;
        digits_in = 16'h1234;
        dp_in     = 4'b0100;
        load      = 1'b1;
        repeat (3 * FRAME) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL basic_scan k=%0d: got %h expected %h", k, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_leading_zero();
        blank_lz  = 1'b1;
        digits_in = 16'h0007;
        dp_in     = 4'b1111;
        load      = 1'b1;
        repeat (3 * FRAME) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL lz_0007 k=%0d: got %h expected %h", k, act_vec, exp_vec);
            end
        end
        digits_in = 16'h0000;
        dp_in     = 4'b0001;
        load      = 1'b1;
        repeat (3 * FRAME) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL lz_0000 k=%0d: got %h expected %h", k, act_vec, exp_vec);
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_mid_frame_load();
        while (k % FRAME != 2 * DIV + 1) step();
        digits_in = 16'h5555;
        dp_in     = 4'b0000;
        load      = 1'b1;
        repeat (3 * FRAME) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL mid_frame_load k=%0d: got %h expected %h", k, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_wrap_load();
        while ((k + 1) % FRAME != 0) step();
        digits_in = 16'h9999;
        dp_in     = 4'b1010;
        load      = 1'b1;
        repeat (3 * FRAME) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL wrap_load k=%0d: got %h expected %h", k, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 30);
            repeat (gap) begin
                step();
                n_checks++;
                if (act_vec !== exp_vec) begin
                    n_fail++;
                    $display("FAIL random k=%0d: got %h expected %h", k, act_vec, exp_vec);
                end
            end
            for (int j = 0; j < 4; j++)
                digits_in[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            dp_in    = 4'($urandom);
            blank_lz = 1'($urandom_range(0, 1));
            load     = 1'b1;
            step();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random_load k=%0d: got %h expected %h", k, act_vec, exp_vec);
            end
        end
        repeat (2 * FRAME) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random_tail k=%0d: got %h expected %h", k, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        digits_in = 16'h8642;
        dp_in     = 4'b1001;
        load      = 1'b1;
        step();
        while ((k - 1) % FRAME != 3 * DIV + 1 || k <= FRAME) step();
        rst = 1'b1;
        step();
        n_checks++;
        if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL reset_mid: got %h expected %h", act_vec, exp_vec);
        end
        rst = 1'b0;
        repeat (2 * FRAME) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL after_reset k=%0d: got %h expected %h", k, act_vec, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_leading_zero();
        test_mid_frame_load();
        test_wrap_load();
        test_back_to_back();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
